// File: rtl/and_ary_pkg.sv
// Shared types, helper functions and parameter-legality checks for the
// serialized AND-ary reducer.
package and_ary_pkg;

  typedef enum logic [0:0] {
    StAccum,
    StHold
  } state_e;

  // Beats needed to stream N operand pairs at W pairs per beat.
  function automatic int unsigned beats_f(input int unsigned n, input int unsigned w);
    return (w == 0) ? 0 : n / w;
  endfunction

  // Beat counter width; at least one bit even when a reduction is a single beat.
  function automatic int unsigned cnt_w_f(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// Elaboration-time legality checks, expanded inside a module body.
`ifndef AND_ARY_ASSERT_W_NONZERO
`define AND_ARY_ASSERT_W_NONZERO(w) \
  if ((w) < 1) begin : g_bad_w \
    $error("and_ary: W must be >= 1"); \
  end
`endif

`ifndef AND_ARY_ASSERT_DIVISIBLE
`define AND_ARY_ASSERT_DIVISIBLE(n, w) \
  if (((w) >= 1) && ((((n) % (w)) != 0) || ((n) < (w)))) begin : g_bad_nw \
    $error("and_ary: N must be a non-zero multiple of W"); \
  end
`endif

// File: rtl/and_ary_lane_reduce.sv
// Combinational W-pair AND reduction: lane_and = &(in_a & in_b), built as a
// balanced binary tree laid out heap-style (node i feeds from 2i+1 and 2i+2).
module and_ary_lane_reduce #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         lane_and
);

  logic [2*W-2:0] node;

  // Leaves hold the pairwise ANDs; internal nodes are filled from the bottom up.
  always_comb begin
    node = '0;
    for (int j = 0; j < int'(W); j++) begin
      node[int'(W) - 1 + j] = in_a[j] & in_b[j];
    end
    for (int i = int'(W) - 2; i >= 0; i--) begin
      node[i] = node[2 * i + 1] & node[2 * i + 2];
    end
  end

  assign lane_and = node[0];

endmodule

// File: rtl/and_ary_seq_reduce.sv
// Serialized AND-ary reducer: folds BEATS beats of W operand pairs into a
// single d0 = AND_i(a_i & b_i), checking in_last framing against the beat count.
module and_ary_seq_reduce
  import and_ary_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_d0,
  output logic         out_err
);

  localparam int unsigned BEATS = beats_f(N, W);
  localparam int unsigned CntW  = cnt_w_f(BEATS);
  localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

  `AND_ARY_ASSERT_W_NONZERO(W)
  `AND_ARY_ASSERT_DIVISIBLE(N, W)

  state_e          state_q, state_d;
  logic            acc_q, acc_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic            err_acc_q, err_acc_d;
  logic            out_d0_q, out_d0_d;
  logic            out_err_q, out_err_d;

  logic lane_and;
  logic is_last;
  logic mismatch;

  and_ary_lane_reduce #(
    .W (W)
  ) u_lane_reduce (
    .in_a     (in_a),
    .in_b     (in_b),
    .lane_and (lane_and)
  );

  assign is_last  = (beat_cnt_q == LastCnt);
  assign mismatch = (in_last != is_last);

  // Next-state: accumulate beats in StAccum, present the result in StHold.
  // The count alone ends a reduction; in_last only feeds the error flag.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    err_acc_d  = err_acc_q;
    out_d0_d   = out_d0_q;
    out_err_d  = out_err_q;
    unique case (state_q)
      StAccum: begin
        if (in_valid) begin
          acc_d     = acc_q & lane_and;
          err_acc_d = err_acc_q | mismatch;
          if (is_last) begin
            out_d0_d  = acc_q & lane_and;
            out_err_d = err_acc_q | mismatch;
            state_d   = StHold;
          end else begin
            beat_cnt_d = beat_cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d    = StAccum;
          acc_d      = 1'b1;
          beat_cnt_d = '0;
          err_acc_d  = 1'b0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAccum;
      acc_q      <= 1'b1;
      beat_cnt_q <= '0;
      err_acc_q  <= 1'b0;
      out_d0_q   <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
      err_acc_q  <= err_acc_d;
      out_d0_q   <= out_d0_d;
      out_err_q  <= out_err_d;
    end
  end

  // Handshake outputs are pure state decodes, so no input reaches an output.
  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StHold);
  assign out_d0    = out_d0_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_and_ary_seq_reduce.sv
// Directed bench for and_ary_seq_reduce: N=16/W=4 instance for the main
// scenarios, N=4/W=4 instance for the single-beat back-to-back case.
module tb_and_ary_seq_reduce;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=16, W=4 instance
  logic       in_valid, in_ready, in_last;
  logic [3:0] in_a, in_b;
  logic       out_valid, out_ready, out_d0, out_err;

  // N=4, W=4 instance
  logic       in_valid1, in_ready1, in_last1;
  logic [3:0] in_a1, in_b1;
  logic       out_valid1, out_ready1, out_d01, out_err1;

  int checks = 0;
  int errors = 0;

  and_ary_seq_reduce #(.N(16), .W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d0    (out_d0),
    .out_err   (out_err)
  );

  and_ary_seq_reduce #(.N(4), .W(4)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .in_last   (in_last1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_d0    (out_d01),
    .out_err   (out_err1)
  );

  // Offer one beat at the negedge, hold it across one rising edge.
  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic last,
                      output logic accepted);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    accepted = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Stream a 4-beat reduction; report whether every beat was taken and
  // whether out_valid showed up before the final beat.
  task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic [3:0] last,
                       output logic all_acc, output logic early);
    logic acc;
    all_acc = 1'b1;
    early   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat(a[k*4 +: 4], b[k*4 +: 4], last[k], acc);
      if (!acc) all_acc = 1'b0;
      if (k < 3 && out_valid !== 1'b0) early = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_last1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_d0, out_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got v/d0/err=%b%b%b want 000", out_valid, out_d0, out_err);
    end
    checks++;
    if ({out_valid1, out_d01, out_err1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs1: got v/d0/err=%b%b%b want 000", out_valid1, out_d01,
               out_err1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready, in_ready1);
    end
  endtask

  // Check the presented result right after the final beat, then consume it.
  task automatic check_result(input string name, input logic all_acc, input logic early,
                              input logic exp_d0, input logic exp_err);
    checks++;
    if (all_acc !== 1'b1 || early !== 1'b0) begin
      errors++;
      $display("FAIL %s_flow: got accepted=%b early=%b want 1 0", name, all_acc, early);
    end
    checks++;
    if (out_valid !== 1'b1 || out_d0 !== exp_d0 || out_err !== exp_err || in_ready !== 1'b0)
    begin
      errors++;
      $display("FAIL %s_result: got v=%b d0=%b err=%b rdy=%b want v=1 d0=%b err=%b rdy=0",
               name, out_valid, out_d0, out_err, in_ready, exp_d0, exp_err);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain: got v=%b rdy=%b want v=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_all_ones();
    logic all_acc, early;
    out_ready = 1'b1;
    send4(16'hFFFF, 16'hFFFF, 4'b1000, all_acc, early);
    check_result("all_ones", all_acc, early, 1'b1, 1'b0);
  endtask

  task automatic test_zero_lane();
    logic all_acc, early;
    // beat 1 carries b = 4'b1011 (lane 2 cleared)
    send4(16'hFFFF, 16'hFFBF, 4'b1000, all_acc, early);
    check_result("zero_lane", all_acc, early, 1'b0, 1'b0);
  endtask

  task automatic test_framing();
    logic all_acc, early;
    send4(16'hFFFF, 16'hFFFF, 4'b1010, all_acc, early);
    check_result("early_last", all_acc, early, 1'b1, 1'b1);
    send4(16'hFFFF, 16'hFFFF, 4'b0000, all_acc, early);
    check_result("missing_last", all_acc, early, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    logic all_acc, early;
    out_ready = 1'b0;
    send4(16'hFFFF, 16'hFFFF, 4'b1000, all_acc, early);
    // Offer all-zero beats while the result is held; none may be consumed.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 4'h0; in_b = 4'h0; in_last = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_d0 !== 1'b1 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b d0=%b err=%b rdy=%b want v=1 d0=1 err=0 rdy=0",
                 c, out_valid, out_d0, out_err, in_ready);
      end
    end
    // Handshake cycle with a zero beat still offered.
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    send4(16'hFFFF, 16'hFFFF, 4'b1000, all_acc, early);
    check_result("bp_next", all_acc, early, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic acc, all_acc, early;
    out_ready = 1'b1;
    beat(4'h0, 4'hF, 1'b0, acc);
    beat(4'hF, 4'hF, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_state: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    send4(16'hFFFF, 16'hFFFF, 4'b1000, all_acc, early);
    check_result("mid_reset_next", all_acc, early, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [6] = '{4'hF, 4'hF, 4'hF, 4'h7, 4'hF, 4'hD};
    logic [3:0] vb [6] = '{4'hF, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF};
    logic       ve [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    out_ready1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid1 = 1'b1; in_a1 = va[k]; in_b1 = vb[k]; in_last1 = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid1 !== 1'b1 || out_d01 !== ve[k] || out_err1 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_result_%0d: got v=%b d0=%b err=%b want v=1 d0=%b err=0",
                 k, out_valid1, out_d01, out_err1, ve[k]);
      end
      // in_valid stays high: the handshake cycle must not accept a beat.
      @(posedge clk);
      #1;
      checks++;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gap_%0d: got v=%b rdy=%b want v=0 rdy=1", k, out_valid1, in_ready1);
      end
    end
    // Single-beat reduction without in_last is a framing error.
    @(negedge clk);
    in_a1 = 4'hF; in_b1 = 4'hF; in_last1 = 1'b0;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b1 || out_d01 !== 1'b1 || out_err1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_last: got v=%b d0=%b err=%b want v=1 d0=1 err=1",
               out_valid1, out_d01, out_err1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_ones();
    test_zero_lane();
    test_framing();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
